// File: rtl/router_fsm_param.sv
// Packet-sequencing FSM for a 1xNUM_CH router: decodes the header address, steers the
// packet into one latched output FIFO, and drops packets that are unroutable or blocked too long.
module router_fsm_param #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              write_enb_reg,
    output logic              busy,
    output logic [NUM_CH-1:0] sel_ch,
    output logic              timeout_err
);
    localparam int CNT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_DECODE, S_LFD, S_LD, S_FULL, S_LAF, S_LP, S_CPE, S_WTE, S_DROP
    } state_t;

    state_t            r_state, w_nxt;
    logic [NUM_CH-1:0] r_sel, w_sel_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_terr, w_terr_nxt;

    logic [NUM_CH-1:0] w_onehot;
    logic              w_addr_ok, w_soft, w_sel_empty, w_cnt_term;

    assign w_addr_ok   = 32'(data_in) < NUM_CH;
    assign w_onehot    = NUM_CH'(1) << data_in;
    assign w_sel_empty = |(fifo_empty & r_sel);
    assign w_cnt_term  = (WAIT_TIMEOUT > 0) && (r_cnt == CNT_W'(WAIT_TIMEOUT - 1));
    // A read-side soft reset on the active channel aborts the packet, except where nothing is being written.
    assign w_soft      = (|(soft_reset & r_sel)) && (r_state != S_DECODE) && (r_state != S_DROP);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_DECODE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    always_comb begin
        w_nxt      = r_state;
        w_sel_nxt  = r_sel;
        w_terr_nxt = 1'b0;
        if (w_soft) begin
            w_nxt     = S_DECODE;
            w_sel_nxt = '0;
        end else begin
            case (r_state)
                S_DECODE: if (pkt_valid) begin
                    if (w_addr_ok) begin
                        w_sel_nxt = w_onehot;
                        w_nxt     = (|(fifo_empty & w_onehot)) ? S_LFD : S_WTE;
                    end else begin
                        w_sel_nxt = '0;
                        w_nxt     = S_DROP;
                    end
                end
                S_LFD:  w_nxt = S_LD;
                S_LD: begin
                    if (fifo_full)       w_nxt = S_FULL;
                    else if (!pkt_valid) w_nxt = S_LP;
                end
                S_FULL: if (!fifo_full) w_nxt = S_LAF;
                S_LAF: begin
                    if (parity_done)        w_nxt = S_DECODE;
                    else if (low_pkt_valid) w_nxt = S_LP;
                    else                    w_nxt = S_LD;
                end
                S_LP:   w_nxt = S_CPE;
                S_CPE: begin
                    if (fifo_full) w_nxt = S_FULL;
                    else begin
                        w_nxt     = S_DECODE;
                        w_sel_nxt = '0;
                    end
                end
                // Draining wins over the timeout when both land on the same cycle.
                S_WTE: begin
                    if (w_sel_empty) w_nxt = S_LFD;
                    else if (w_cnt_term) begin
                        w_nxt      = S_DROP;
                        w_terr_nxt = 1'b1;
                    end
                end
                S_DROP: if (!pkt_valid) begin
                    w_nxt     = S_DECODE;
                    w_sel_nxt = '0;
                end
                default: begin
                    w_nxt     = S_DECODE;
                    w_sel_nxt = '0;
                end
            endcase
        end
        w_cnt_nxt = (r_state == S_WTE && w_nxt == S_WTE) ? r_cnt + CNT_W'(1) : '0;
    end

    always_comb begin
        detect_add    = (r_state == S_DECODE);
        lfd_state     = (r_state == S_LFD);
        ld_state      = (r_state == S_LD);
        full_state    = (r_state == S_FULL);
        laf_state     = (r_state == S_LAF);
        rst_int_reg   = (r_state == S_CPE);
        drop_state    = (r_state == S_DROP);
        write_enb_reg = (r_state == S_LD) || (r_state == S_LAF) || (r_state == S_LP);
        busy          = (r_state == S_LFD) || (r_state == S_FULL) || (r_state == S_LAF) ||
                        (r_state == S_LP)  || (r_state == S_CPE)  || (r_state == S_WTE);
        sel_ch        = r_sel;
        timeout_err   = r_terr;
    end
endmodule

// File: tb/tb_router_fsm_param.sv
// Scoreboard bench: two router FSM instances (4 channels and 3 channels, timeout 8)
// driven by directed packets; expected output vectors are queued and checked by a monitor.
module tb_router_fsm_param;
    localparam int D = 0, F = 1, L = 2, U = 3, A = 4, P = 5, C = 6, W = 7, X = 8;

    typedef struct {
        string       name;
        bit          d3;
        logic [13:0] v;
    } exp_t;

    logic       clock, resetn, pkt_valid, parity_done, low_pkt_valid, fifo_full;
    logic [1:0] data_in;
    logic [3:0] fe4, sr4;
    logic [2:0] fe3, sr3;

    logic       da4, lfd4, ld4, fs4, laf4, rir4, dr4, we4, bz4, te4;
    logic [3:0] sel4;
    logic       da3, lfd3, ld3, fs3, laf3, rir3, dr3, we3, bz3, te3;
    logic [2:0] sel3;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    router_fsm_param #(.NUM_CH(4), .WAIT_TIMEOUT(8)) dut4 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fe4), .soft_reset(sr4),
        .detect_add(da4), .lfd_state(lfd4), .ld_state(ld4), .full_state(fs4),
        .laf_state(laf4), .rst_int_reg(rir4), .drop_state(dr4), .write_enb_reg(we4),
        .busy(bz4), .sel_ch(sel4), .timeout_err(te4)
    );

    router_fsm_param #(.NUM_CH(3), .WAIT_TIMEOUT(8)) dut3 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fe3), .soft_reset(sr3),
        .detect_add(da3), .lfd_state(lfd3), .ld_state(ld3), .full_state(fs3),
        .laf_state(laf3), .rst_int_reg(rir3), .drop_state(dr3), .write_enb_reg(we3),
        .busy(bz3), .sel_ch(sel3), .timeout_err(te3)
    );

    wire [13:0] a4 = {da4, lfd4, ld4, fs4, laf4, rir4, dr4, we4, bz4, te4, sel4};
    wire [13:0] a3 = {da3, lfd3, ld3, fs3, laf3, rir3, dr3, we3, bz3, te3, 1'b0, sel3};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    // Expected vector {detect,lfd,ld,full,laf,rst_int,drop,wen,busy,terr,sel[3:0]}
    function automatic logic [13:0] mk(input int st, input logic [3:0] sel, input logic te);
        logic [9:0] f;
        case (st)
            D:       f = 10'b1000000000;
            F:       f = 10'b0100000010;
            L:       f = 10'b0010000100;
            U:       f = 10'b0001000010;
            A:       f = 10'b0000100110;
            P:       f = 10'b0000000110;
            C:       f = 10'b0000010010;
            W:       f = 10'b0000000010;
            X:       f = 10'b0000001000;
            default: f = 10'b0;
        endcase
        f[0] = te;
        return {f, sel};
    endfunction

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, e.d3 ? a3 : a4, e.v);
            end
        end
    endtask

    // Queue the state expected after the coming edge, then advance to the next negedge.
    task automatic ex(input string nm, input bit d3, input int st, input logic [3:0] sel,
                      input logic te = 1'b0);
        exp_t e;
        e.name = nm;
        e.d3   = d3;
        e.v    = mk(st, sel, te);
        q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        fork
            monitor();
        join_none

        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
        low_pkt_valid = 1'b0; fifo_full = 1'b0;
        fe4 = 4'b1111; sr4 = 4'b0000; fe3 = 3'b111; sr3 = 3'b000;
        #3;
        chk("reset_dut4", a4, mk(D, 4'b0000, 1'b0));
        chk("reset_dut3", a3, mk(D, 4'b0000, 1'b0));
        @(negedge clock);
        resetn = 1'b1;
        idle(1);

        // Straight packet to channel 2
        pkt_valid = 1'b1; data_in = 2'd2;
        ex("t1_lfd", 0, F, 4'b0100);
        ex("t1_ld1", 0, L, 4'b0100);
        ex("t1_ld2", 0, L, 4'b0100);
        ex("t1_ld3", 0, L, 4'b0100);
        pkt_valid = 1'b0;
        ex("t1_lp",  0, P, 4'b0100);
        ex("t1_cp",  0, C, 4'b0100);
        ex("t1_dec", 0, D, 4'b0000);
        idle(2);

        // FIFO full stall on channel 1
        pkt_valid = 1'b1; data_in = 2'd1;
        ex("t2_lfd", 0, F, 4'b0010);
        ex("t2_ld",  0, L, 4'b0010);
        fifo_full = 1'b1;
        ex("t2_full1", 0, U, 4'b0010);
        pkt_valid = 1'b0;
        ex("t2_full2", 0, U, 4'b0010);
        ex("t2_full3", 0, U, 4'b0010);
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        ex("t2_laf", 0, A, 4'b0010);
        ex("t2_lp",  0, P, 4'b0010);
        low_pkt_valid = 1'b0;
        ex("t2_cp",  0, C, 4'b0010);
        ex("t2_dec", 0, D, 4'b0000);
        idle(2);

        // Out-of-range address on the 3-channel instance
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 5; i++) ex($sformatf("t3_drop%0d", i), 1, X, 4'b0000);
        pkt_valid = 1'b0;
        ex("t3_dec", 1, D, 4'b0000);
        idle(6);

        // Blocked channel 0 times out after 8 cycles
        fe4 = 4'b1110; pkt_valid = 1'b1; data_in = 2'd0;
        for (int i = 0; i < 8; i++) ex($sformatf("t4_wait%0d", i), 0, W, 4'b0001);
        ex("t4_drop_terr", 0, X, 4'b0001, 1'b1);
        ex("t4_drop_noterr", 0, X, 4'b0001, 1'b0);
        pkt_valid = 1'b0;
        ex("t4_dec", 0, D, 4'b0000);
        idle(6);

        // Channel drains on the terminal cycle: empty beats timeout
        fe4 = 4'b1110; pkt_valid = 1'b1; data_in = 2'd0;
        for (int i = 0; i < 8; i++) ex($sformatf("t5_wait%0d", i), 0, W, 4'b0001);
        fe4 = 4'b1111;
        ex("t5_lfd_noterr", 0, F, 4'b0001);
        ex("t5_ld", 0, L, 4'b0001);
        pkt_valid = 1'b0;
        ex("t5_lp",  0, P, 4'b0001);
        ex("t5_cp",  0, C, 4'b0001);
        ex("t5_dec", 0, D, 4'b0000);
        idle(6);

        // Soft reset: unselected channel ignored, selected channel aborts
        pkt_valid = 1'b1; data_in = 2'd2;
        ex("t6_lfd", 0, F, 4'b0100);
        ex("t6_ld",  0, L, 4'b0100);
        sr4 = 4'b0001;
        ex("t7_soft_unsel", 0, L, 4'b0100);
        sr4 = 4'b0100;
        ex("t6_soft_sel", 0, D, 4'b0000);
        sr4 = 4'b0000; pkt_valid = 1'b0;
        ex("t6_stay_dec", 0, D, 4'b0000);
        idle(4);

        // Asynchronous reset mid-payload, checked between clock edges
        pkt_valid = 1'b1; data_in = 2'd2;
        ex("t8_lfd", 0, F, 4'b0100);
        ex("t8_ld",  0, L, 4'b0100);
        #2 resetn = 1'b0;
        #1;
        chk("t8_async_rst", a4, mk(D, 4'b0000, 1'b0));
        @(negedge clock);
        resetn = 1'b1; pkt_valid = 1'b0;
        ex("t8_after_rst", 0, D, 4'b0000);
        idle(2);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL q_drained: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_fsm_param.md
Name: router_fsm_param

Overview:
Parametrised successor to the 1x3 router control FSM. It sequences one input packet stream into one of NUM_CH output FIFOs: address decode, header load, payload load, full-stall, parity load and parity check. New relative to the fixed 1x3 controller: a channel count set by parameter, a latched one-hot channel select, a drop path for out-of-range addresses, and a WAIT_TILL_EMPTY timeout that discards a blocked packet. It sits between the router register block (parity/low_pkt_valid) and the synchroniser/FIFO array.

Parameters:
NUM_CH, 3, number of output channels (2..16)
ADDR_W, $clog2(NUM_CH) (min 1), width of address field data_in
WAIT_TIMEOUT, 64, cycles allowed in WAIT_TILL_EMPTY before drop; 0 disables timeout

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  packet byte valid from source
data_in  in  ADDR_W  address bits of header byte
parity_done  in  1  parity byte captured (register block)
low_pkt_valid  in  1  pkt_valid fell while FIFO was full (register block)
fifo_full  in  1  full flag of currently selected FIFO
fifo_empty  in  NUM_CH  per-channel FIFO empty
soft_reset  in  NUM_CH  per-channel soft reset from read-side timeouts
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
full_state  out  1  in FIFO_FULL_STATE
laf_state  out  1  in LOAD_AFTER_FULL
rst_int_reg  out  1  in CHECK_PARITY_ERROR
drop_state  out  1  in DROP_PACKET
write_enb_reg  out  1  byte write to register block this cycle
busy  out  1  source must hold current byte
sel_ch  out  NUM_CH  one-hot latched destination, 0 when none
timeout_err  out  1  one-cycle pulse on WAIT_TILL_EMPTY timeout

Behaviour:
- One clock; reset is asynchronous and active-low. Ports are named clock and resetn.
- Moore outputs, decoded from the state register only. sel_ch, the wait counter and timeout_err are registered.
- Reset values:
  - state = DECODE_ADDRESS, so detect_add=1.
  - All other outputs = 0.
  - sel_ch = 0; wait counter = 0.
- DECODE_ADDRESS (busy=0):
  - pkt_valid && data_in<NUM_CH && fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid && data_in<NUM_CH && !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
  - pkt_valid && data_in>=NUM_CH -> DROP_PACKET.
  - Otherwise stay.
  - sel_ch is loaded with the one-hot of data_in on a valid-address exit, cleared to 0 on a drop exit, and held otherwise.
- LOAD_FIRST_DATA (busy=1, write_enb_reg=0) -> LOAD_DATA unconditionally.
- LOAD_DATA (busy=0, write_enb_reg=1):
  - fifo_full -> FIFO_FULL_STATE.
  - Else !pkt_valid -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE (busy=1, write_enb_reg=0): !fifo_full -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL (busy=1, write_enb_reg=1):
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY (busy=1, write_enb_reg=1) -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR (busy=1, write_enb_reg=0):
  - fifo_full -> FIFO_FULL_STATE.
  - Else -> DECODE_ADDRESS, and sel_ch clears to 0.
- WAIT_TILL_EMPTY (busy=1, write_enb_reg=0):
  - The wait counter increments each cycle spent here.
  - A sel_ch channel that is empty -> LOAD_FIRST_DATA (empty has priority over timeout on the same cycle).
  - Else, if WAIT_TIMEOUT>0 and the counter reaches WAIT_TIMEOUT-1 -> DROP_PACKET, with timeout_err=1 in the following cycle only.
  - The counter clears on every exit from this state.
- DROP_PACKET (busy=0, write_enb_reg=0, drop_state=1):
  - Consumes the remaining packet bytes without writing.
  - !pkt_valid -> DECODE_ADDRESS, and sel_ch clears to 0.
- Soft reset:
  - If soft_reset & sel_ch is nonzero in any state other than DECODE_ADDRESS or DROP_PACKET, next state = DECODE_ADDRESS and sel_ch clears to 0.
  - This has priority over every other transition.
  - soft_reset on a channel that is not selected is ignored.
- Latency from header at DECODE_ADDRESS to the first payload write_enb_reg is 2 cycles.
- Asynchronous reset mid-packet forces DECODE_ADDRESS immediately; the partial packet is abandoned.
- Only a single destination is active at a time; no new packet is accepted before the FSM returns to DECODE_ADDRESS.

Test Plan:
- NUM_CH=4, fifo_empty=4'b1111, pkt_valid=1, data_in=2 for 4 cycles, then 0 -> required response:
  - States DECODE→LFD→LD×3→LOAD_PARITY→CHECK_PARITY→DECODE.
  - sel_ch=4'b0100 during the packet.
  - write_enb_reg high in LD and LOAD_PARITY.
- NUM_CH=4, data_in=1, fifo_full=1 raised in LD for 3 cycles, then dropped; low_pkt_valid=1 -> required response:
  - FIFO_FULL_STATE held 3 cycles with busy=1.
  - Then LAF→LOAD_PARITY→CHECK_PARITY→DECODE.
- NUM_CH=3, data_in=3 (out of range), pkt_valid high 5 cycles -> required response:
  - DROP_PACKET for 5 cycles with write_enb_reg=0 and sel_ch=0.
  - DECODE on the cycle after pkt_valid falls.
- WAIT_TIMEOUT=8, fifo_empty[0]=0 held, data_in=0 -> required response:
  - 8 cycles in WAIT_TILL_EMPTY.
  - Then DROP_PACKET, with a single-cycle timeout_err pulse.
- Same setup as the previous case, but fifo_empty[0] rises on the counter's terminal cycle -> required response: LOAD_FIRST_DATA, no timeout_err.
- Mid-LD, soft_reset=4'b0100 with sel_ch=4'b0100 -> required response: DECODE next cycle, sel_ch=0.
- Mid-LD, soft_reset=4'b0001 with sel_ch=4'b0100 -> required response: no effect.
- Mid-LD, resetn pulsed low -> required response: DECODE immediately, without waiting for a clock edge.
